// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data, optional even
// parity, stop bit, each held for DIV clocks. The line idles high.
module serial_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIV    = 4,
  parameter int unsigned PARITY = 0
) (
  input  logic             clk,
  input  logic             preset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             q
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  div_cnt_q, div_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             q_q, q_d;
  logic             bit_done;
  logic             accept;

  always_comb begin
    bit_done  = (div_cnt_q == DivLast);
    // The last stop-bit cycle also accepts, so back-to-back frames have no idle gap.
    accept    = load && ((state_q == StIdle) || ((state_q == StStop) && bit_done));
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;

    if (state_q != StIdle) begin
      div_cnt_d = bit_done ? '0 : div_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? StPar : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StPar: begin
        if (bit_done) state_d = StStop;
      end
      StStop: begin
        if (bit_done) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      state_d   = StStart;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = d;
      par_d     = (PARITY != 0) ? ^d : 1'b0;
    end

    // Line value follows the next state so q is registered yet aligned with it.
    case (state_d)
      StStart: q_d = 1'b0;
      StData:  q_d = shift_d[0];
      StPar:   q_d = par_d;
      default: q_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      q_q       <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      q_q       <= q_d;
    end
  end

  assign q     = q_q;
  assign ready = (state_q == StIdle);
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a no-parity and an even-parity instance share the inputs and are
// checked every cycle against a per-cycle queue of expected line values.
module tb_serial_tx;

  localparam int unsigned Div = 4;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       preset = 1'b1;
  logic [7:0] d      = 8'h00;
  logic       load   = 1'b0;
  logic       ready0, busy0, q0;
  logic       ready1, busy1, q1;

  int total = 0;
  int bad   = 0;

  logic exp0[$];
  logic exp1[$];

  always #5 if (clk_en) clk = ~clk;

  serial_tx #(.WIDTH(8), .DIV(Div), .PARITY(0)) u_np (
    .clk(clk), .preset(preset), .d(d), .load(load),
    .ready(ready0), .busy(busy0), .q(q0)
  );

  serial_tx #(.WIDTH(8), .DIV(Div), .PARITY(1)) u_par (
    .clk(clk), .preset(preset), .d(d), .load(load),
    .ready(ready1), .busy(busy1), .q(q1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bit idx: 0 = start, 1..8 = data LSB first, then parity (if any), then stop.
  function automatic logic model_bit(input logic [7:0] w, input int par, input int idx);
    logic [7:0] wv;
    wv = w;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return wv[idx-1];
    if (par != 0 && idx == 9) return logic'($countones(wv) % 2);
    return 1'b1;
  endfunction

  // Reference model and per-cycle compare.
  initial begin
    forever begin
      @(posedge clk or negedge preset);
      if (!preset) begin
        exp0.delete();
        exp1.delete();
      end else begin
        if (exp0.size() > 0) void'(exp0.pop_front());
        if (exp1.size() > 0) void'(exp1.pop_front());
        if (load && exp0.size() == 0)
          for (int b = 0; b < 10; b++)
            for (int c = 0; c < Div; c++) exp0.push_back(model_bit(d, 0, b));
        if (load && exp1.size() == 0)
          for (int b = 0; b < 11; b++)
            for (int c = 0; c < Div; c++) exp1.push_back(model_bit(d, 1, b));
      end
      #1;
      chk("np_q",     q0,     exp0.size() > 0 ? exp0[0] : 1'b1);
      chk("np_ready", ready0, exp0.size() == 0);
      chk("np_busy",  busy0,  exp0.size() != 0);
      chk("par_q",     q1,     exp1.size() > 0 ? exp1[0] : 1'b1);
      chk("par_ready", ready1, exp1.size() == 0);
      chk("par_busy",  busy1,  exp1.size() != 0);
    end
  end

  initial begin
    logic [9:0] lit;
    lit = 10'b1101001010;  // A5 frame, index 0 = start bit

    for (int j = 0; j < 10; j++) chk("model_pin_a5", model_bit(8'hA5, 0, j), lit[j]);
    chk("model_pin_par07", model_bit(8'h07, 1, 9), 1'b1);

    // Asynchronous reset with the clock stopped.
    #5 preset = 1'b0;
    #2;
    chk("rst_q", q0, 1'b1);
    chk("rst_ready", ready0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_par_q", q1, 1'b1);
    #3 clk_en = 1'b1;
    repeat (2) @(negedge clk);
    preset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic A5 frame, with a 3C load pulse mid-frame that must be ignored.
    d = 8'hA5;
    load = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("basic_q", q0, lit[k/4]);
      if (k >= 36) chk("basic_par_bit_a5", q1, 1'b0);
      load = (k == 11);
      d = (k == 11) ? 8'h3C : 8'hA5;
    end
    @(negedge clk);
    chk("basic_ready41", ready0, 1'b1);
    chk("basic_par_busy41", busy1, 1'b1);
    repeat (10) @(negedge clk);

    // Parity frame for 07.
    d = 8'h07;
    load = 1'b1;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k >= 36 && k < 40) chk("par_bit_07", q1, 1'b1);
    end
    @(negedge clk);
    chk("par_ready45", ready1, 1'b1);
    repeat (5) @(negedge clk);

    // Back-to-back: 00 then FF with load held high.
    d = 8'h00;
    load = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      d = 8'hFF;
      if (k >= 36 && k < 40) chk("b2b_stop", q0, 1'b1);
      if (k == 40) begin
        chk("b2b_start", q0, 1'b0);
        chk("b2b_ready", ready0, 1'b0);
      end
    end
    load = 1'b0;
    repeat (100) @(negedge clk);

    // Reset during data bit 3, then a clean 5A frame.
    d = 8'hA5;
    load = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      load = 1'b0;
    end
    #2 preset = 1'b0;
    #1;
    chk("midrst_q", q0, 1'b1);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_ready", ready0, 1'b1);
    repeat (2) @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    d = 8'h5A;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (50) @(negedge clk);

    // Randomized loads and data.
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      load = ($urandom_range(0, 5) == 0);
      d = 8'($urandom);
    end
    load = 1'b0;
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
